ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver feeding the SOC keyboard I/O port.
- Synchronises and de-glitches the raw kb_clk / kb_data pins.
- Deframes 11-bit device-to-host frames and checks start, parity and stop bits.
- Buffers good scan codes in a first-word-fall-through FIFO that the SOC bus logic pops.
- Sits between the board pins and the SOC keyboard device register.

Parameters:
- FIFO_DEPTH, 8: scan-code FIFO entries; power of two, at least 2.
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered kb_clk changes state.
- TIMEOUT_CYCLES, 200000: idle clk cycles allowed mid-frame before abort (2 ms at 100 MHz).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset; asserted when 0.
- kb_clk, in, 1: raw PS/2 clock pin.
- kb_data, in, 1: raw PS/2 data pin.
- rd_en, in, 1: pop the FIFO head; ignored when empty.
- clr_ovf, in, 1: clear the sticky overflow flag.
- dout, out, 8 (9 with PS2_BREAK_TAG_EN): FIFO head scan code.
- valid, out, 1: FIFO non-empty.
- overflow, out, 1: sticky; a good frame was dropped because the FIFO was full.
- err_cnt, out, 8: saturating count of rejected and timed-out frames.

Behaviour:
- Reset values (async on reset=0): dout=0, valid=0, overflow=0, err_cnt=0. FSM=IDLE, FIFO empty, sync/filter registers=1 (bus idle-high).
- Input path: 2-FF synchroniser on both pins. Filtered kb_clk toggles only after FILTER_LEN equal synchronised samples. A filtered 1->0 transition produces a one-cycle fall pulse. kb_data is sampled from the synchronised value in the fall cycle.
- FSM, advancing only on fall:
  - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay IDLE (no error).
  - DATA: shift 8 bits LSB first -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: frame is good if XOR of 8 data bits and parity bit =1 and stop bit =1. Always return to IDLE.
- Good frame: pushed to the FIFO in the clk cycle after the stop-bit fall; valid rises the following cycle.
- Bad frame (parity or stop error): discarded, err_cnt+1.
- Timeout: a counter clears on every fall and increments while FSM != IDLE. Reaching TIMEOUT_CYCLES forces IDLE, clears the shift register and bit count, and adds err_cnt+1.
- err_cnt saturates at 255.
- FIFO:
  - dout always shows the head entry.
  - rd_en with valid=1 advances the head on the next edge.
  - Push while full with no pop: entry dropped, overflow set.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: push only.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- overflow: cleared by clr_ovf. If clr_ovf and a new overflow occur in the same cycle, set wins.
- Reset mid-frame: partial frame lost, FIFO cleared, no error counted.

Optional Feature:
- Macro: PS2_BREAK_TAG_EN.
- Defined: dout widens to 9 bits. A good 0xF0 byte is not pushed; it sets a break flag. The next good byte is pushed with dout[8]=1 and the flag clears. A bad frame, timeout or reset also clears the flag. Other bytes push with dout[8]=0.
- Undefined: every good byte, including 0xF0, is pushed as 8 bits; no break flag exists.

Test Plan:
1. Frame start 0, data 0x1C, parity 0, stop 1, at 12.5 kHz PS/2 clock -> valid=1 two cycles after the stop fall; dout=0x1C. rd_en one cycle -> valid=0. err_cnt=0.
2. Same frame with parity 1 -> valid stays 0, err_cnt=1. A following good 0x32 frame -> dout=0x32.
3. Nine good frames 0x01..0x09 with no reads, depth 8 -> overflow=1. Eight pops return 0x01..0x08 in order. clr_ovf -> overflow=0.
4. Start bit plus 4 data bits, then pins held high past TIMEOUT_CYCLES -> err_cnt=1, FSM IDLE. Next full 0x5A frame -> dout=0x5A.
5. A 1-cycle low glitch on kb_clk (shorter than FILTER_LEN) during IDLE -> no state change, no push. reset=0 asserted mid-frame -> all outputs return to reset values immediately.
6. With PS2_BREAK_TAG_EN defined: frames 0xF0 then 0x1C -> exactly one entry, dout=0x11C. A following 0x1C -> dout=0x01C.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin sync + clock de-glitch, 11-bit frame check, FWFT scan-code FIFO.
// Optional PS2_BREAK_TAG_EN: 0xF0 is absorbed and tags the next byte via o_dout[8].
module ps2_kbd_rx #(
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_kb_clk,
   input  logic       i_kb_data,
   input  logic       i_rd_en,
   input  logic       i_clr_ovf,
`ifdef PS2_BREAK_TAG_EN
   output logic [8:0] o_dout,
`else
   output logic [7:0] o_dout,
`endif
   output logic       o_valid,
   output logic       o_overflow,
   output logic [7:0] o_err_cnt,
   output logic [1:0] o_state
);
   // FIFO handshake: an entry is offered while o_valid=1; i_rd_en with o_valid=1 consumes o_dout at the edge.
`ifdef PS2_BREAK_TAG_EN
   localparam int DW = 9;
`else
   localparam int DW = 8;
`endif
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_filt;
   logic [FW-1:0]   r_filt_cnt;
   logic [7:0]      r_shift;
   logic [2:0]      r_bit_cnt;
   logic            r_parity;
   logic [TW-1:0]   r_to_cnt;
   logic            r_push;
   logic [DW-1:0]   r_push_data;
   logic [7:0]      r_err_cnt;
   logic            r_overflow;
   logic [DW-1:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
   logic            w_fall, w_good, w_bad, w_timeout;
   logic            w_empty, w_full, w_pop, w_wr;
`ifdef PS2_BREAK_TAG_EN
   logic            r_brk;
`endif

   // Pins idle high, so synchronisers and filter come out of reset at 1.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_clk_filt <= 1'b1;
         r_filt_cnt <= '0;
      end else begin
         r_clk_s1 <= i_kb_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= i_kb_data;
         r_dat_s2 <= r_dat_s1;
         if (r_clk_s2 != r_clk_filt) begin
            if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
               r_clk_filt <= r_clk_s2;
               r_filt_cnt <= '0;
            end else begin
               r_filt_cnt <= r_filt_cnt + FW'(1);
            end
         end else begin
            r_filt_cnt <= '0;
         end
      end
   end

   assign w_fall = r_clk_filt && !r_clk_s2 && (r_filt_cnt == FW'(FILTER_LEN - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      w_timeout   = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES));
      if (w_timeout) begin
         w_state_nxt = S_IDLE;
      end else if (w_fall) begin
         case (r_state)
            S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
            S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: w_state_nxt = S_STOP;
            S_STOP: begin
               w_state_nxt = S_IDLE;
               if ((^{r_shift, r_parity}) && r_dat_s2) w_good = 1'b1;
               else                                    w_bad  = 1'b1;
            end
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_parity    <= 1'b0;
         r_to_cnt    <= '0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_err_cnt   <= '0;
`ifdef PS2_BREAK_TAG_EN
         r_brk       <= 1'b0;
`endif
      end else begin
         r_push <= 1'b0;
         if (w_timeout) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
         end else if (w_fall) begin
            r_to_cnt <= '0;
            case (r_state)
               S_IDLE: r_bit_cnt <= '0;
               S_DATA: begin
                  r_shift   <= {r_dat_s2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
               S_PARITY: r_parity <= r_dat_s2;
               default: ;
            endcase
         end else if (r_state != S_IDLE) begin
            r_to_cnt <= r_to_cnt + TW'(1);
         end else begin
            r_to_cnt <= '0;
         end
         if ((w_bad || w_timeout) && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
`ifdef PS2_BREAK_TAG_EN
         if (w_good) begin
            if (r_shift == 8'hF0) begin
               r_brk <= 1'b1;
            end else begin
               r_push      <= 1'b1;
               r_push_data <= {r_brk, r_shift};
               r_brk       <= 1'b0;
            end
         end else if (w_bad || w_timeout) begin
            r_brk <= 1'b0;
         end
`else
         if (w_good) begin
            r_push      <= 1'b1;
            r_push_data <= r_shift;
         end
`endif
      end
   end

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = i_rd_en && !w_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_wr    = r_push && (!w_full || w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
         else if (i_clr_ovf)             r_overflow <= 1'b0;
      end
   end

   assign o_dout     = r_mem[r_rd_ptr[AW-1:0]];
   assign o_valid    = !w_empty;
   assign o_overflow = r_overflow;
   assign o_err_cnt  = r_err_cnt;
   assign o_state    = r_state;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: pin-level PS/2 frame driver, queue-based reference model, per-scenario checks.
// Build with PS2_BREAK_TAG_EN defined to also cover the break-tag scenario.
module tb_ps2_kbd_rx;
   localparam int DEPTH = 8;
   localparam int FLEN  = 4;
   localparam int TMO   = 400;
   localparam int HP    = 25;
`ifdef PS2_BREAK_TAG_EN
   localparam int DW = 9;
`else
   localparam int DW = 8;
`endif

   logic          clk, rst_n, kb_clk, kb_data, rd_en, clr_ovf;
   logic [DW-1:0] dout;
   logic          valid, overflow;
   logic [7:0]    err_cnt;
   logic [1:0]    state;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   logic [DW-1:0] exp_q[$];
   int            exp_err = 0;
   logic          exp_ovf = 1'b0;
   logic          exp_brk = 1'b0;

   ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_kb_clk(kb_clk), .i_kb_data(kb_data),
      .i_rd_en(rd_en), .i_clr_ovf(clr_ovf), .o_dout(dout), .o_valid(valid),
      .o_overflow(overflow), .o_err_cnt(err_cnt), .o_state(state)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // drivers
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
      logic par;
      par = (~^d) ^ bad_par;
      return {~bad_stop, par, d, 1'b0};
   endfunction

   // Drives nbits of the frame LSB first; with split=1 returns right at the last clock fall.
   task automatic send_frame(input logic [10:0] f, input int hp, input int nbits, input logic split);
      for (int i = 0; i < nbits; i++) begin
         kb_data = f[i];
         wait_cyc(hp);
         kb_clk = 1'b0;
         if (split && (i == nbits - 1)) return;
         wait_cyc(hp);
         kb_clk = 1'b1;
      end
      kb_data = 1'b1;
   endtask

   task automatic finish_frame(input int hp);
      wait_cyc(hp);
      kb_clk  = 1'b1;
      kb_data = 1'b1;
      wait_cyc(4);
   endtask

   task automatic do_pop();
      @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic model_push(input logic [DW-1:0] v);
      if (exp_q.size() < DEPTH) exp_q.push_back(v);
      else                      exp_ovf = 1'b1;
   endtask

   task automatic model_frame(input logic [10:0] f);
      logic [7:0] d;
      logic       good;
      d    = f[8:1];
      good = (f[0] == 1'b0) && ((^f[9:1]) == 1'b1) && (f[10] == 1'b1);
      if (good) begin
`ifdef PS2_BREAK_TAG_EN
         if (d == 8'hF0) exp_brk = 1'b1;
         else begin
            model_push({exp_brk, d});
            exp_brk = 1'b0;
         end
`else
         model_push(d);
`endif
      end else begin
         if (exp_err < 255) exp_err++;
         exp_brk = 1'b0;
      end
   endtask

   task automatic model_abort();
      if (exp_err < 255) exp_err++;
      exp_brk = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      rst_n = 1'b0; kb_clk = 1'b1; kb_data = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
      wait_cyc(3);
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h expected 0", valid); end
      n_tests++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %0h expected 0", dout); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0h expected 0", overflow); end
      n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
      n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
      rst_n = 1'b1;
      wait_cyc(5);
   endtask

   task automatic test_good_frame();
      logic [10:0] f;
      f = mk_frame(8'h1C, 1'b0, 1'b0);
      send_frame(f, HP, 11, 1'b1);
      wait_cyc(6);
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL good_early_valid: got %0h expected 0", valid); end
      wait_cyc(1);
      model_frame(f);
      n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL good_valid_latency: got %0h expected 1", valid); end
      n_tests++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL good_dout: got %0h expected %0h", dout, exp_q[0]); end
      finish_frame(HP);
      n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL good_err: got %0d expected %0d", err_cnt, exp_err); end
      do_pop();
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL good_pop_valid: got %0h expected 0", valid); end
   endtask

   task automatic test_parity_err();
      logic [10:0] f;
      f = mk_frame(8'h1C, 1'b1, 1'b0);
      send_frame(f, HP, 11, 1'b0);
      model_frame(f);
      wait_cyc(5);
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL parity_valid: got %0h expected 0", valid); end
      n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL parity_err: got %0d expected %0d", err_cnt, exp_err); end
      f = mk_frame(8'h32, 1'b0, 1'b0);
      send_frame(f, HP, 11, 1'b0);
      model_frame(f);
      wait_cyc(5);
      n_tests++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL parity_next_dout: got %0h expected %0h", dout, exp_q[0]); end
      do_pop();
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL parity_pop_valid: got %0h expected 0", valid); end
   endtask

   task automatic test_overflow();
      logic [10:0] f;
      for (int i = 1; i <= 9; i++) begin
         f = mk_frame(8'(i), 1'b0, 1'b0);
         send_frame(f, HP, 11, 1'b0);
         model_frame(f);
      end
      wait_cyc(5);
      n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_set: got %0h expected %0h", overflow, exp_ovf); end
      @(negedge clk); clr_ovf = 1'b1;
      @(negedge clk); clr_ovf = 1'b0;
      exp_ovf = 1'b0;
      n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_clear: got %0h expected %0h", overflow, exp_ovf); end
      // clear held while another push hits the full FIFO: the set must win that cycle
      clr_ovf = 1'b1;
      f = mk_frame(8'h0A, 1'b0, 1'b0);
      send_frame(f, HP, 11, 1'b1);
      wait_cyc(7);
      model_frame(f);
      n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_set_wins: got %0h expected %0h", overflow, exp_ovf); end
      wait_cyc(1);
      exp_ovf = 1'b0;
      n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_clear_after: got %0h expected %0h", overflow, exp_ovf); end
      clr_ovf = 1'b0;
      finish_frame(HP);
      for (int i = 0; i < DEPTH; i++) begin
         n_tests++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL ovf_order[%0d]: got %0h expected %0h", i, dout, exp_q[0]); end
         do_pop();
      end
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %0h expected 0", valid); end
   endtask

   task automatic test_back_to_back();
      logic [10:0] f;
      for (int i = 0; i < DEPTH; i++) begin
         f = mk_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
         if (f[8:1] == 8'hF0) f = mk_frame(8'h3C, 1'b0, 1'b0);
         send_frame(f, HP, 11, 1'b0);
         model_frame(f);
      end
      // pop lands exactly on the push edge while full
      f = mk_frame(8'h6B, 1'b0, 1'b0);
      send_frame(f, HP, 11, 1'b1);
      wait_cyc(6);
      rd_en = 1'b1;
      wait_cyc(1);
      rd_en = 1'b0;
      void'(exp_q.pop_front());
      model_frame(f);
      finish_frame(HP);
      n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL b2b_full_ovf: got %0h expected %0h", overflow, exp_ovf); end
      for (int i = 0; i < DEPTH; i++) begin
         n_tests++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL b2b_full_order[%0d]: got %0h expected %0h", i, dout, exp_q[0]); end
         do_pop();
      end
      // pop on the push edge while empty: only the push takes effect
      f = mk_frame(8'h29, 1'b0, 1'b0);
      send_frame(f, HP, 11, 1'b1);
      wait_cyc(6);
      rd_en = 1'b1;
      wait_cyc(1);
      rd_en = 1'b0;
      model_frame(f);
      n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_empty_valid: got %0h expected 1", valid); end
      n_tests++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL b2b_empty_dout: got %0h expected %0h", dout, exp_q[0]); end
      finish_frame(HP);
      do_pop();
   endtask

   task automatic test_timeout();
      logic [10:0] f;
      f = mk_frame(8'hA5, 1'b0, 1'b0);
      send_frame(f, HP, 5, 1'b0);
      n_tests++; if (state === 2'd0) begin n_fail++; $display("FAIL timeout_midframe_state: got %0d expected non-idle", state); end
      wait_cyc(TMO + 100);
      model_abort();
      n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL timeout_err: got %0d expected %0d", err_cnt, exp_err); end
      n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL timeout_state: got %0d expected 0", state); end
      f = mk_frame(8'h5A, 1'b0, 1'b0);
      send_frame(f, HP, 11, 1'b0);
      model_frame(f);
      wait_cyc(5);
      n_tests++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL timeout_next_dout: got %0h expected %0h", dout, exp_q[0]); end
      do_pop();
   endtask

   task automatic test_glitch();
      for (int w = 1; w < FLEN; w++) begin
         @(negedge clk);
         kb_data = 1'b0;
         kb_clk  = 1'b0;
         wait_cyc(w);
         kb_clk  = 1'b1;
         wait_cyc(8);
         kb_data = 1'b1;
         wait_cyc(4);
         n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL glitch_state[w=%0d]: got %0d expected 0", w, state); end
      end
      wait_cyc(TMO + 50);
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %0h expected 0", valid); end
      n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL glitch_err: got %0d expected %0d", err_cnt, exp_err); end
   endtask

   task automatic test_random();
      logic [10:0] f;
      int          kind, hp;
      for (int it = 0; it < 24; it++) begin
         kind = $urandom_range(0, 9);
         hp   = $urandom_range(8, 30);
         f    = mk_frame(8'($urandom_range(0, 255)), kind == 0, kind == 1);
         send_frame(f, hp, 11, 1'b0);
         model_frame(f);
         wait_cyc(6);
         n_tests++; if (valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %0h expected %0h", it, valid, exp_q.size() > 0); end
         if (exp_q.size() > 0) begin
            n_tests++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL rand_dout[%0d]: got %0h expected %0h", it, dout, exp_q[0]); end
         end
         n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL rand_err[%0d]: got %0d expected %0d", it, err_cnt, exp_err); end
         n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %0h expected %0h", it, overflow, exp_ovf); end
         if (($urandom_range(0, 2) != 0) && (exp_q.size() > 0)) do_pop();
      end
      while (exp_q.size() > 0) begin
         n_tests++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL rand_drain: got %0h expected %0h", dout, exp_q[0]); end
         do_pop();
      end
      @(negedge clk); clr_ovf = 1'b1;
      @(negedge clk); clr_ovf = 1'b0;
      exp_ovf = 1'b0;
   endtask

   task automatic test_err_saturation();
      logic [10:0] f;
      int          n;
      n = 258 - exp_err;
      for (int i = 0; i < n; i++) begin
         f = mk_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
         send_frame(f, 6, 11, 1'b0);
         model_frame(f);
         wait_cyc(2);
      end
      wait_cyc(8);
      n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL err_saturate: got %0d expected %0d", err_cnt, exp_err); end
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL err_sat_valid: got %0h expected 0", valid); end
   endtask

   task automatic test_reset_midframe();
      logic [10:0] f;
      f = mk_frame(8'h77, 1'b0, 1'b0);
      send_frame(f, HP, 11, 1'b0);
      model_frame(f);
      f = mk_frame(8'h44, 1'b0, 1'b0);
      send_frame(f, HP, 5, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_q.delete(); exp_err = 0; exp_ovf = 1'b0; exp_brk = 1'b0;
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0h expected 0", valid); end
      n_tests++; if (dout !== '0) begin n_fail++; $display("FAIL midrst_dout: got %0h expected 0", dout); end
      n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_err: got %0d expected 0", err_cnt); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %0h expected 0", overflow); end
      n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", state); end
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(10);
      f = mk_frame(8'h21, 1'b0, 1'b0);
      send_frame(f, HP, 11, 1'b0);
      model_frame(f);
      wait_cyc(5);
      n_tests++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL midrst_next_dout: got %0h expected %0h", dout, exp_q[0]); end
      n_tests++; if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL midrst_next_err: got %0d expected %0d", err_cnt, exp_err); end
      do_pop();
   endtask

`ifdef PS2_BREAK_TAG_EN
   task automatic test_break_tag();
      send_frame(mk_frame(8'hF0, 1'b0, 1'b0), HP, 11, 1'b0);
      send_frame(mk_frame(8'h1C, 1'b0, 1'b0), HP, 11, 1'b0);
      wait_cyc(5);
      n_tests++; if (dout !== 9'h11C) begin n_fail++; $display("FAIL brk_tagged: got %0h expected 11c", dout); end
      @(negedge clk); rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL brk_one_entry: got %0h expected 0", valid); end
      send_frame(mk_frame(8'h1C, 1'b0, 1'b0), HP, 11, 1'b0);
      wait_cyc(5);
      n_tests++; if (dout !== 9'h01C) begin n_fail++; $display("FAIL brk_untagged: got %0h expected 01c", dout); end
      @(negedge clk); rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
      send_frame(mk_frame(8'hF0, 1'b0, 1'b0), HP, 11, 1'b0);
      send_frame(mk_frame(8'h12, 1'b1, 1'b0), HP, 11, 1'b0);
      send_frame(mk_frame(8'h1C, 1'b0, 1'b0), HP, 11, 1'b0);
      wait_cyc(5);
      n_tests++; if (dout !== 9'h01C) begin n_fail++; $display("FAIL brk_cleared_by_bad: got %0h expected 01c", dout); end
      @(negedge clk); rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_good_frame();
      test_parity_err();
      test_overflow();
      test_back_to_back();
      test_timeout();
      test_glitch();
      test_random();
      test_err_saturation();
      test_reset_midframe();
`ifdef PS2_BREAK_TAG_EN
      test_break_tag();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
